// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer that walks fetch, operand, execute,
// write-back and interrupt entry states, strobing register-file and memory controls.
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_rdy,
    input  logic [1:0] fmt,
    input  logic [1:0] As,
    input  logic       Ad,
    input  logic [3:0] srcA,
    input  logic       push,
    input  logic       jmp_taken,
    input  logic       irq,
    input  logic       GIE,
    output logic       IF,
    output logic       IdxF,
    output logic       SPF,
    output logic       INTACK,
    output logic       Ex,
    output logic       RW,
    output logic       srcInc,
    output logic       MW,
    output logic [2:0] mab_sel,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        RESET_VEC = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        SRC_IDX   = 4'd3,
        SRC_RD    = 4'd4,
        DST_IDX   = 4'd5,
        DST_RD    = 4'd6,
        EXEC      = 4'd7,
        WB_MEM    = 4'd8,
        INT_PC    = 4'd9,
        INT_SR    = 4'd10,
        INT_VEC   = 4'd11
    } state_t;

    localparam logic [2:0] MAB_PC  = 3'd0;
    localparam logic [2:0] MAB_SRC = 3'd1;
    localparam logic [2:0] MAB_DST = 3'd2;
    localparam logic [2:0] MAB_SP  = 3'd3;
    localparam logic [2:0] MAB_VEC = 3'd4;

    state_t cur, nxt;

    logic dbl, sgl, jmp, src_const, go, int_req, wb_push, to_wb, next_instr;

    assign state      = cur;
    assign dbl        = fmt == 2'b00;
    assign sgl        = fmt == 2'b01;
    assign jmp        = fmt == 2'b10;
    // Constant-generator registers never touch memory for their source operand.
    assign src_const  = (srcA == 4'd3) || (srcA == 4'd2 && As[1]);
    // Strobes fire only in the completing cycle, and never while reset is held.
    assign go         = mem_rdy & rst;
    assign int_req    = irq & GIE;
    assign wb_push    = sgl & push;
    assign to_wb      = wb_push | (dbl & Ad) | (sgl & (As != 2'b00));
    assign next_instr = int_req ? 1'b1 : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cur <= RESET_VEC;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt     = cur;
        IF      = 1'b0;
        IdxF    = 1'b0;
        SPF     = 1'b0;
        INTACK  = 1'b0;
        Ex      = 1'b0;
        RW      = 1'b0;
        srcInc  = 1'b0;
        MW      = 1'b0;
        mab_sel = MAB_PC;
        case (cur)
            RESET_VEC: begin
                mab_sel = MAB_VEC;
                INTACK  = go;
                nxt     = mem_rdy ? FETCH : RESET_VEC;
            end
            FETCH: begin
                mab_sel = MAB_PC;
                IF      = go;
                nxt     = mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                if ((dbl || sgl) && !src_const && As == 2'b01)
                    nxt = SRC_IDX;
                else if ((dbl || sgl) && !src_const && As[1])
                    nxt = SRC_RD;
                else
                    nxt = (dbl && Ad) ? DST_IDX : EXEC;
            end
            SRC_IDX: begin
                mab_sel = MAB_PC;
                IdxF    = go;
                nxt     = mem_rdy ? SRC_RD : SRC_IDX;
            end
            SRC_RD: begin
                mab_sel = MAB_SRC;
                IdxF    = go & (As == 2'b11) & (srcA == 4'd0);
                srcInc  = go & (As == 2'b11) & (srcA != 4'd0);
                nxt     = !mem_rdy ? SRC_RD : (dbl && Ad) ? DST_IDX : EXEC;
            end
            DST_IDX: begin
                mab_sel = MAB_PC;
                IdxF    = go;
                nxt     = mem_rdy ? DST_RD : DST_IDX;
            end
            DST_RD: begin
                mab_sel = MAB_DST;
                nxt     = mem_rdy ? EXEC : DST_RD;
            end
            EXEC: begin
                Ex  = rst & (fmt != 2'b11);
                RW  = rst & ((dbl & ~Ad) | (sgl & (As == 2'b00) & ~push) | (jmp & jmp_taken));
                SPF = rst & wb_push;
                nxt = to_wb ? WB_MEM : next_instr ? INT_PC : FETCH;
            end
            WB_MEM: begin
                mab_sel = wb_push ? MAB_SP : MAB_DST;
                MW      = go;
                nxt     = !mem_rdy ? WB_MEM : next_instr ? INT_PC : FETCH;
            end
            INT_PC: begin
                mab_sel = MAB_SP;
                SPF     = go;
                MW      = go;
                nxt     = mem_rdy ? INT_SR : INT_PC;
            end
            INT_SR: begin
                mab_sel = MAB_SP;
                SPF     = go;
                MW      = go;
                nxt     = mem_rdy ? INT_VEC : INT_SR;
            end
            INT_VEC: begin
                mab_sel = MAB_VEC;
                INTACK  = go;
                nxt     = mem_rdy ? FETCH : INT_VEC;
            end
            default: nxt = RESET_VEC;
        endcase
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed per-cycle scoreboard for cpu_sequencer; expectations are
// queued as each cycle's stimulus is driven and checked at the following negedge.
module tb_cpu_sequencer;
    logic       clk, rst, mem_rdy, Ad, push, jmp_taken, irq, GIE;
    logic [1:0] fmt, As;
    logic [3:0] srcA;
    logic       IF, IdxF, SPF, INTACK, Ex, RW, srcInc, MW;
    logic [2:0] mab_sel;
    logic [3:0] state;

    localparam logic [7:0] S_IF  = 8'h80;
    localparam logic [7:0] S_IDX = 8'h40;
    localparam logic [7:0] S_SPF = 8'h20;
    localparam logic [7:0] S_ACK = 8'h10;
    localparam logic [7:0] S_EX  = 8'h08;
    localparam logic [7:0] S_RW  = 8'h04;
    localparam logic [7:0] S_INC = 8'h02;
    localparam logic [7:0] S_MW  = 8'h01;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [7:0] stb;
        logic [2:0] mab;
        bit         chk_mab;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .mem_rdy(mem_rdy), .fmt(fmt), .As(As), .Ad(Ad),
        .srcA(srcA), .push(push), .jmp_taken(jmp_taken), .irq(irq), .GIE(GIE),
        .IF(IF), .IdxF(IdxF), .SPF(SPF), .INTACK(INTACK), .Ex(Ex), .RW(RW),
        .srcInc(srcInc), .MW(MW), .mab_sel(mab_sel), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: queue the expectation, compare at negedge, return just after the next posedge.
    task automatic cyc(input string tag, input int st, input logic [7:0] stb, input int mab);
        exp_t e, o;
        logic [7:0] obs;
        e.tag = tag;
        e.st = st[3:0];
        e.stb = stb;
        e.mab = mab[2:0];
        e.chk_mab = mab >= 0;
        q.push_back(e);
        @(negedge clk);
        o = q.pop_front();
        obs = {IF, IdxF, SPF, INTACK, Ex, RW, srcInc, MW};
        checks++;
        assert (state === o.st) else begin
            errors++;
            $error("FAIL %s state obs=%0d exp=%0d", o.tag, state, o.st);
        end
        checks++;
        assert (obs === o.stb) else begin
            errors++;
            $error("FAIL %s strobes obs=%b exp=%b", o.tag, obs, o.stb);
        end
        if (o.chk_mab) begin
            checks++;
            assert (mab_sel === o.mab) else begin
                errors++;
                $error("FAIL %s mab_sel obs=%0d exp=%0d", o.tag, mab_sel, o.mab);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] f, input logic [1:0] as, input logic ad,
                         input logic [3:0] sa, input logic p, input logic jt);
        fmt = f; As = as; Ad = ad; srcA = sa; push = p; jmp_taken = jt;
    endtask

    initial begin
        rst = 1'b0; mem_rdy = 1'b1; irq = 1'b0; GIE = 1'b0;
        instr(2'b00, 2'b00, 1'b0, 4'd4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cyc("in_reset", 0, 8'h00, 4);
        rst = 1'b1;
        cyc("rst_vec", 0, S_ACK, 4);
        mem_rdy = 1'b0;
        cyc("ws1", 1, 8'h00, 0);
        cyc("ws2", 1, 8'h00, 0);
        cyc("ws3", 1, 8'h00, 0);
        mem_rdy = 1'b1;
        instr(2'b00, 2'b01, 1'b1, 4'd5, 1'b0, 1'b0);
        cyc("ws_fetch", 1, S_IF, 0);
        cyc("idx_dec", 2, 8'h00, -1);
        cyc("idx_sidx", 3, S_IDX, 0);
        cyc("idx_srd", 4, 8'h00, 1);
        cyc("idx_didx", 5, S_IDX, 0);
        cyc("idx_drd", 6, 8'h00, 2);
        cyc("idx_exec", 7, S_EX, -1);
        cyc("idx_wb", 8, S_MW, 2);
        instr(2'b00, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc("imm_fetch", 1, S_IF, 0);
        cyc("imm_dec", 2, 8'h00, -1);
        cyc("imm_srd", 4, S_IDX, 1);
        cyc("imm_exec", 7, S_EX | S_RW, -1);
        instr(2'b00, 2'b11, 1'b0, 4'd4, 1'b0, 1'b0);
        cyc("inc_fetch", 1, S_IF, 0);
        cyc("inc_dec", 2, 8'h00, -1);
        mem_rdy = 1'b0;
        cyc("inc_wait", 4, 8'h00, 1);
        mem_rdy = 1'b1;
        cyc("inc_srd", 4, S_INC, 1);
        cyc("inc_exec", 7, S_EX | S_RW, -1);
        instr(2'b00, 2'b10, 1'b0, 4'd3, 1'b0, 1'b0);
        cyc("cg_fetch", 1, S_IF, 0);
        cyc("cg_dec", 2, 8'h00, -1);
        cyc("cg_exec", 7, S_EX | S_RW, -1);
        instr(2'b01, 2'b00, 1'b0, 4'd6, 1'b0, 1'b0);
        irq = 1'b1; GIE = 1'b1;
        cyc("int_fetch", 1, S_IF, 0);
        cyc("int_dec", 2, 8'h00, -1);
        cyc("int_exec", 7, S_EX | S_RW, -1);
        irq = 1'b0;
        cyc("int_pc", 9, S_SPF | S_MW, 3);
        cyc("int_sr", 10, S_SPF | S_MW, 3);
        cyc("int_vec", 11, S_ACK, 4);
        instr(2'b10, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1);
        irq = 1'b1; GIE = 1'b0;
        cyc("jmp_fetch", 1, S_IF, 0);
        cyc("jmp_dec", 2, 8'h00, -1);
        cyc("jmp_exec", 7, S_EX | S_RW, -1);
        irq = 1'b0;
        instr(2'b01, 2'b00, 1'b0, 4'd7, 1'b1, 1'b0);
        cyc("push_fetch", 1, S_IF, 0);
        cyc("push_dec", 2, 8'h00, -1);
        cyc("push_exec", 7, S_EX | S_SPF, -1);
        cyc("push_wb", 8, S_MW, 3);
        instr(2'b11, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc("nop_fetch", 1, S_IF, 0);
        cyc("nop_dec", 2, 8'h00, -1);
        cyc("nop_exec", 7, 8'h00, -1);
        instr(2'b00, 2'b00, 1'b0, 4'd4, 1'b0, 1'b0);
        cyc("rx_fetch", 1, S_IF, 0);
        cyc("rx_dec", 2, 8'h00, -1);
        #1 rst = 1'b0;
        cyc("rst_mid_exec", 0, 8'h00, 4);
        rst = 1'b1;
        cyc("rx_vec", 0, S_ACK, 4);
        cyc("rx_fetch2", 1, S_IF, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port mem_rdy, input, 1, memory handshake; current memory access completes in a cycle with mem_rdy=1.
REQ-004 SHALL have port fmt, input, 2, instruction format: 00 double-op, 01 single-op, 10 jump, 11 illegal.
REQ-005 SHALL have port As, input, 2, source addressing mode.
REQ-006 SHALL have port Ad, input, 1, destination addressing mode.
REQ-007 SHALL have port srcA, input, 4, source register select.
REQ-008 SHALL have port push, input, 1, single-op is PUSH/CALL.
REQ-009 SHALL have port jmp_taken, input, 1, jump condition true.
REQ-010 SHALL have port irq, input, 1, maskable interrupt pending.
REQ-011 SHALL have port GIE, input, 1, global interrupt enable.
REQ-012 SHALL have outputs IF, IdxF, SPF, INTACK, Ex, RW, srcInc, MW, each 1 bit: register file strobes plus memory write.
REQ-013 SHALL have port mab_sel, output, 3, address source: 0 PC, 1 src EA, 2 dst EA, 3 SP-2, 4 vector.
REQ-014 SHALL have port state, output, 4, current state code.

Function
REQ-015 SHALL implement these states: RESET_VEC=0, FETCH=1, DECODE=2, SRC_IDX=3, SRC_RD=4, DST_IDX=5, DST_RD=6, EXEC=7, WB_MEM=8, INT_PC=9, INT_SR=10, INT_VEC=11.
REQ-016 SHALL treat memory states as RESET_VEC, FETCH, SRC_IDX, SRC_RD, DST_IDX, DST_RD, WB_MEM and INT_*; each holds while mem_rdy=0 and advances on the cycle mem_rdy=1.
REQ-017 SHALL assert strobes combinationally, only in the completing cycle (mem_rdy=1), so each increment or decrement occurs exactly once per access.
REQ-018 SHALL drive RESET_VEC as INTACK, mab_sel=4, then go to FETCH; FETCH as IF, mab_sel=0, then go to DECODE.
REQ-019 SHALL make DECODE a single cycle with no strobes, dispatching on fields latched externally at FETCH.
REQ-020 SHALL treat the source as constant (no memory) when srcA=3, or when srcA=2 and As[1]=1.
REQ-021 SHALL route DECODE as follows for fmt 00/01: As=01, non-constant -> SRC_IDX; As=1x, non-constant -> SRC_RD; otherwise double-op -> DST_IDX if Ad=1, else EXEC.
REQ-022 SHALL drive SRC_IDX as IdxF, mab_sel=0, then go to SRC_RD.
REQ-023 SHALL drive SRC_RD with mab_sel=1; As=11 with srcA=0 (immediate) asserts IdxF and not srcInc; As=11 with another register asserts srcInc.
REQ-024 SHALL advance SRC_RD to DST_IDX for a double-op with Ad=1, else to EXEC; SHALL drive DST_IDX as IdxF -> DST_RD (mab_sel=2) -> EXEC.
REQ-025 SHALL assert Ex for exactly one cycle in EXEC; RW=1 when (double-op, Ad=0), (single-op, As=00, push=0), or (jump with jmp_taken=1).
REQ-026 SHALL assert SPF in EXEC when push=1 and go to WB_MEM; SHALL also go to WB_MEM for a double-op with Ad=1 or a single-op with As!=00.
REQ-027 SHALL drive WB_MEM as MW, mab_sel=3 if push, else 2.
REQ-028 SHALL treat fmt=11 as a NOP: EXEC with Ex=0, RW=0.
REQ-029 SHALL sample irq&GIE at instruction end (leaving EXEC without WB_MEM, or leaving WB_MEM): if 1 -> INT_PC, else FETCH.
REQ-030 SHALL drive INT_PC and INT_SR each as SPF, MW, mab_sel=3; SHALL drive INT_VEC as INTACK, mab_sel=4, then go to FETCH.
REQ-031 SHALL ignore irq outside instruction boundaries; irq deasserting during INT_* SHALL NOT abort the sequence.

Reset
REQ-032 SHALL force state=RESET_VEC and all strobes 0 on rst=0 at any time, including mid-instruction; SHALL resume at the first posedge after rst=1.

Verification
REQ-033 SHALL verify reset: rst=0 during EXEC -> state=0 immediately; after release with mem_rdy=1 -> INTACK 1 cycle, then IF.
REQ-034 SHALL verify wait states: FETCH with mem_rdy low 3 cycles -> IF only in 4th cycle, state stays 1.
REQ-035 SHALL verify double-op As=01, srcA=5, Ad=1 -> sequence 1,2,3,4,5,6,7,8; IdxF twice; MW once; RW=0.
REQ-036 SHALL verify immediate: As=11, srcA=0, Ad=0 -> SRC_RD asserts IdxF=1, srcInc=0; EXEC has RW=1.
REQ-037 SHALL verify constant source: As=10, srcA=3 -> DECODE goes straight to EXEC.
REQ-038 SHALL verify interrupt: irq=1, GIE=1 at EXEC end -> 9,10,11 with SPF twice, INTACK once, then FETCH; with GIE=0 -> FETCH.
